// File: rtl/corevx_imem_responder.sv
// corevx_imem_responder
// Responder end of the core's cache command interface, backed by a
// word-addressed on-chip instruction RAM. EXECUTE reads a word after a
// configurable latency and FLUSH_ALL completes after a fixed delay. A
// backdoor write port loads the RAM. All outputs are registered.
//
// Optional feature: define COREVX_IMEM_PAGEFAULT_EN so that aligned EXECUTE
// addresses in [PF_BASE, PF_BASE+PF_SIZE) return PAGEFAULT.
//
// Command/response encodings come from corevx_cache.svh. The fallback
// definitions below are used only when that header has not been included.

`ifndef CACHE_CMD_NONE
`define CACHE_CMD_NONE              4'h0
`define CACHE_CMD_LOAD              4'h1
`define CACHE_CMD_STORE             4'h2
`define CACHE_CMD_EXECUTE           4'h3
`define CACHE_CMD_FLUSH_ALL         4'h4
`endif

`ifndef CACHE_RESPONSE_IDLE
`define CACHE_RESPONSE_IDLE         4'h0
`define CACHE_RESPONSE_WAIT         4'h1
`define CACHE_RESPONSE_DONE         4'h2
`define CACHE_RESPONSE_MISSALIGNED  4'h3
`define CACHE_RESPONSE_ACCESSFAULT  4'h4
`define CACHE_RESPONSE_PAGEFAULT    4'h5
`endif

module corevx_imem_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_2000,
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          LATENCY      = 2,
  parameter int          FLUSH_CYCLES = 4,
  parameter int          RESET_CYCLES = 8,
  parameter logic [31:0] PF_BASE      = 32'h0000_3000,
  parameter logic [31:0] PF_SIZE      = 32'h0000_0100,
  localparam int         IDX_W        = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       c_cmd,
  input  logic [31:0]      c_address,
  output logic [3:0]       c_response,
  output logic [31:0]      c_load_data,
  output logic             c_reset_done,
  input  logic             w_en,
  input  logic [IDX_W-1:0] w_index,
  input  logic [31:0]      w_data
);

  // One counter serves the init, access and flush delays, so it is sized
  // for the longest of them.
  localparam int MAX_LF  = (LATENCY > FLUSH_CYCLES) ? LATENCY : FLUSH_CYCLES;
  localparam int MAX_CYC = (RESET_CYCLES > MAX_LF) ? RESET_CYCLES : MAX_LF;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // RAM window bounds kept in 33 bits so BASE_ADDR + size cannot wrap.
  localparam logic [32:0] RAM_LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] RAM_HI = RAM_LO + (33'(DEPTH_WORDS) << 2);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_BUSY,
    ST_FLUSH
  } state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   counter, counter_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [3:0]         resp_d;
  logic               reset_done_d;
  logic               load_mem;
  logic               load_zero;
  logic [IDX_W-1:0]   rd_index;

  logic [31:0]        mem [DEPTH_WORDS];

  // Address decode of the incoming command.
  logic [32:0]        addr_ext;
  logic               misaligned;
  logic               out_of_range;
  logic               pf_hit;
  logic [IDX_W-1:0]   acc_index;

  assign addr_ext     = {1'b0, c_address};
  assign misaligned   = |c_address[1:0];
  assign out_of_range = (addr_ext < RAM_LO) || (addr_ext >= RAM_HI);
  assign acc_index    = IDX_W'((c_address - BASE_ADDR) >> 2);

`ifdef COREVX_IMEM_PAGEFAULT_EN
  localparam logic [32:0] PF_LO = {1'b0, PF_BASE};
  localparam logic [32:0] PF_HI = PF_LO + {1'b0, PF_SIZE};
  assign pf_hit = (addr_ext >= PF_LO) && (addr_ext < PF_HI);
`else
  assign pf_hit = 1'b0;
`endif

  // Backdoor write port; active in every state, including reset and INIT.
  // NOTE: the RAM array has no reset on purpose: contents survive rst_n and
  // a reset branch here would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (w_en) begin
      mem[w_index] <= w_data;
    end
  end

  // Next-state and next-output decode for the responder FSM.
  // NOTE: every signal is given a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state;
    counter_d    = counter;
    index_d      = index_q;
    resp_d       = `CACHE_RESPONSE_IDLE;
    reset_done_d = c_reset_done;
    load_mem     = 1'b0;
    load_zero    = 1'b0;
    rd_index     = index_q;

    case (state)
      ST_INIT: begin
        if (counter == CNT_W'(RESET_CYCLES - 1)) begin
          state_d      = ST_IDLE;
          counter_d    = '0;
          reset_done_d = 1'b1;
        end else begin
          counter_d = counter + CNT_W'(1);
        end
      end

      // Accept point: IDLE covers cycles showing IDLE, DONE or an error.
      ST_IDLE: begin
        rd_index = acc_index;
        case (c_cmd)
          `CACHE_CMD_EXECUTE: begin
            if (misaligned) begin
              resp_d = `CACHE_RESPONSE_MISSALIGNED;
            end else if (pf_hit) begin
              resp_d = `CACHE_RESPONSE_PAGEFAULT;
            end else if (out_of_range) begin
              resp_d = `CACHE_RESPONSE_ACCESSFAULT;
            end else begin
              index_d   = acc_index;
              counter_d = '0;
              if (LATENCY == 1) begin
                resp_d   = `CACHE_RESPONSE_DONE;
                load_mem = 1'b1;
              end else begin
                state_d = ST_BUSY;
                resp_d  = `CACHE_RESPONSE_WAIT;
              end
            end
          end
          `CACHE_CMD_FLUSH_ALL: begin
            counter_d = '0;
            if (FLUSH_CYCLES == 1) begin
              resp_d    = `CACHE_RESPONSE_DONE;
              load_zero = 1'b1;
            end else begin
              state_d = ST_FLUSH;
              resp_d  = `CACHE_RESPONSE_WAIT;
            end
          end
          default: resp_d = `CACHE_RESPONSE_IDLE;
        endcase
      end

      // Latched access: inputs ignored until DONE.
      ST_BUSY: begin
        if (counter == CNT_W'(LATENCY - 2)) begin
          state_d  = ST_IDLE;
          resp_d   = `CACHE_RESPONSE_DONE;
          load_mem = 1'b1;
        end else begin
          counter_d = counter + CNT_W'(1);
          resp_d    = `CACHE_RESPONSE_WAIT;
        end
      end

      ST_FLUSH: begin
        if (counter == CNT_W'(FLUSH_CYCLES - 2)) begin
          state_d   = ST_IDLE;
          resp_d    = `CACHE_RESPONSE_DONE;
          load_zero = 1'b1;
        end else begin
          counter_d = counter + CNT_W'(1);
          resp_d    = `CACHE_RESPONSE_WAIT;
        end
      end

      default: begin
        state_d   = ST_INIT;
        counter_d = '0;
      end
    endcase
  end

  // State, counter and registered outputs with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_INIT;
      counter      <= '0;
      index_q      <= '0;
      c_response   <= `CACHE_RESPONSE_IDLE;
      c_reset_done <= 1'b0;
      c_load_data  <= '0;
    end else begin
      state        <= state_d;
      counter      <= counter_d;
      index_q      <= index_d;
      c_response   <= resp_d;
      c_reset_done <= reset_done_d;
      // The RAM is read at the DONE-producing edge, so a backdoor write that
      // landed on an earlier edge is visible; one on this edge is not.
      if (load_mem) begin
        c_load_data <= mem[rd_index];
      end else if (load_zero) begin
        c_load_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_corevx_imem_responder.sv
// Self-checking bench for corevx_imem_responder (default parameters).
// Table-driven single accesses go through a scoreboard queue; hand-written
// sequences cover reset release, back-to-back access, write collision and
// reset during an access.

`ifndef CACHE_CMD_NONE
`define CACHE_CMD_NONE              4'h0
`define CACHE_CMD_LOAD              4'h1
`define CACHE_CMD_STORE             4'h2
`define CACHE_CMD_EXECUTE           4'h3
`define CACHE_CMD_FLUSH_ALL         4'h4
`endif

`ifndef CACHE_RESPONSE_IDLE
`define CACHE_RESPONSE_IDLE         4'h0
`define CACHE_RESPONSE_WAIT         4'h1
`define CACHE_RESPONSE_DONE         4'h2
`define CACHE_RESPONSE_MISSALIGNED  4'h3
`define CACHE_RESPONSE_ACCESSFAULT  4'h4
`define CACHE_RESPONSE_PAGEFAULT    4'h5
`endif

module tb_corevx_imem_responder;

  localparam logic [3:0] CMD_NONE  = `CACHE_CMD_NONE;
  localparam logic [3:0] CMD_LOAD  = `CACHE_CMD_LOAD;
  localparam logic [3:0] CMD_EXEC  = `CACHE_CMD_EXECUTE;
  localparam logic [3:0] CMD_FLUSH = `CACHE_CMD_FLUSH_ALL;
  localparam logic [3:0] R_IDLE    = `CACHE_RESPONSE_IDLE;
  localparam logic [3:0] R_WAIT    = `CACHE_RESPONSE_WAIT;
  localparam logic [3:0] R_DONE    = `CACHE_RESPONSE_DONE;
  localparam logic [3:0] R_MIS     = `CACHE_RESPONSE_MISSALIGNED;
  localparam logic [3:0] R_AF      = `CACHE_RESPONSE_ACCESSFAULT;
`ifdef COREVX_IMEM_PAGEFAULT_EN
  localparam logic [3:0] R_PF_WIN  = `CACHE_RESPONSE_PAGEFAULT;
`else
  localparam logic [3:0] R_PF_WIN  = `CACHE_RESPONSE_ACCESSFAULT;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  c_cmd;
  logic [31:0] c_address;
  logic [3:0]  c_response;
  logic [31:0] c_load_data;
  logic        c_reset_done;
  logic        w_en;
  logic [9:0]  w_index;
  logic [31:0] w_data;

  corevx_imem_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .c_cmd        (c_cmd),
    .c_address    (c_address),
    .c_response   (c_response),
    .c_load_data  (c_load_data),
    .c_reset_done (c_reset_done),
    .w_en         (w_en),
    .w_index      (w_index),
    .w_data       (w_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  resp;
    logic [31:0] data;
    int          waits;
  } exp_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [3:0]  resp;
    logic [31:0] data;
    int          waits;
  } vec_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  // Advance one clock and sample #1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ram_write(input logic [9:0] idx, input logic [31:0] data);
    w_en = 1'b1; w_index = idx; w_data = data;
    tick();
    w_en = 1'b0;
  endtask

  // Issue one command from an accept point, push its expectation, hold it
  // until a non-WAIT response arrives, then pop and compare.
  task automatic run_access(input string name, input logic [3:0] cmd, input logic [31:0] addr,
                            input logic [3:0] resp, input logic [31:0] data, input int waits);
    exp_t e;
    int   seen_waits;
    bit   got;
    sb.push_back('{resp: resp, data: data, waits: waits});
    c_cmd = cmd; c_address = addr;
    seen_waits = 0; got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      tick();
      if (c_response == R_WAIT) seen_waits++;
      else got = 1'b1;
    end
    c_cmd = CMD_NONE;
    e = sb.pop_front();
    if (!got) begin
      timeout_fail(name);
    end else begin
      check({name, " resp"}, 32'(c_response), 32'(e.resp));
      check({name, " data"}, c_load_data, e.data);
      check({name, " waits"}, seen_waits, e.waits);
      if (c_response == R_DONE) last_data = c_load_data;
    end
    tick();
    check({name, " idle after"}, 32'(c_response), 32'(R_IDLE));
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{CMD_EXEC,  32'h0000_2000, R_DONE,   32'h0000_0013, 1};
    vecs[1]  = '{CMD_EXEC,  32'h0000_201C, R_DONE,   32'hCAFE_F00D, 1};
    vecs[2]  = '{CMD_EXEC,  32'h0000_2002, R_MIS,    32'h0,         0};
    vecs[3]  = '{CMD_EXEC,  32'h0000_2FFC, R_DONE,   32'hDEAD_BEEF, 1};
    vecs[4]  = '{CMD_EXEC,  32'h0000_1FFC, R_AF,     32'h0,         0};
    vecs[5]  = '{CMD_EXEC,  32'h0000_3000, R_PF_WIN, 32'h0,         0};
    vecs[6]  = '{CMD_EXEC,  32'hFFFF_FFFC, R_AF,     32'h0,         0};
    vecs[7]  = '{CMD_EXEC,  32'h0000_3002, R_MIS,    32'h0,         0};
    vecs[8]  = '{CMD_FLUSH, 32'h0000_2000, R_DONE,   32'h0,         3};
    vecs[9]  = '{CMD_EXEC,  32'h0000_2001, R_MIS,    32'h0,         0};
    vecs[10] = '{CMD_EXEC,  32'h0000_30FC, R_PF_WIN, 32'h0,         0};
    vecs[11] = '{CMD_EXEC,  32'h0000_0000, R_AF,     32'h0,         0};
    vecs[12] = '{CMD_EXEC,  32'h0000_2004, R_DONE,   32'h00A0_0093, 1};

    rst_n = 1'b0; c_cmd = CMD_NONE; c_address = '0;
    w_en = 1'b0; w_index = '0; w_data = '0;
    tick();
    tick();
    // Backdoor loads while held in reset.
    ram_write(10'd0,    32'h0000_0013);
    ram_write(10'd1,    32'h00A0_0093);
    ram_write(10'd2,    32'h1111_1111);
    ram_write(10'd7,    32'hCAFE_F00D);
    ram_write(10'd1023, 32'hDEAD_BEEF);
    check("reset resp", 32'(c_response), 32'(R_IDLE));
    check("reset done", 32'(c_reset_done), 32'd0);
    check("reset data", c_load_data, 32'd0);

    // Release reset with a command present; it must be ignored during INIT.
    c_cmd = CMD_EXEC; c_address = 32'h0000_2000;
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("init done k=%0d", k), 32'(c_reset_done), (k == 8) ? 32'd1 : 32'd0);
      check($sformatf("init resp k=%0d", k), 32'(c_response), 32'(R_IDLE));
    end
    c_cmd = CMD_NONE;
    tick();
    check("post-init resp", 32'(c_response), 32'(R_IDLE));
    check("post-init done", 32'(c_reset_done), 32'd1);

    // Back-to-back: second command issued in the DONE cycle.
    c_cmd = CMD_EXEC; c_address = 32'h0000_2000;
    tick(); check("b2b wait0", 32'(c_response), 32'(R_WAIT));
    tick(); check("b2b done0", 32'(c_response), 32'(R_DONE));
    check("b2b data0", c_load_data, 32'h0000_0013);
    c_address = 32'h0000_2004;
    tick(); check("b2b wait1", 32'(c_response), 32'(R_WAIT));
    check("b2b hold", c_load_data, 32'h0000_0013);
    tick(); check("b2b done1", 32'(c_response), 32'(R_DONE));
    check("b2b data1", c_load_data, 32'h00A0_0093);
    c_cmd = CMD_NONE;
    last_data = 32'h00A0_0093;
    tick(); check("b2b idle", 32'(c_response), 32'(R_IDLE));

    // Table of single accesses; non-DONE responses keep the last DONE data.
    foreach (vecs[i]) begin
      run_access($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].addr, vecs[i].resp,
                 (vecs[i].resp == R_DONE) ? vecs[i].data : last_data, vecs[i].waits);
    end

    // Unknown encoding at an accept point yields IDLE.
    c_cmd = CMD_LOAD; c_address = 32'h0000_2000;
    tick(); check("load resp", 32'(c_response), 32'(R_IDLE));
    tick(); check("load resp2", 32'(c_response), 32'(R_IDLE));
    check("load hold", c_load_data, last_data);
    c_cmd = CMD_NONE;

    // Write on the DONE-producing edge is not seen.
    c_cmd = CMD_EXEC; c_address = 32'h0000_2008;
    tick(); check("coll late wait", 32'(c_response), 32'(R_WAIT));
    w_en = 1'b1; w_index = 10'd2; w_data = 32'h2222_2222;
    tick(); w_en = 1'b0;
    check("coll late resp", 32'(c_response), 32'(R_DONE));
    check("coll late data", c_load_data, 32'h1111_1111);
    c_cmd = CMD_NONE;
    tick();
    // Write landing on the accept edge is seen.
    c_cmd = CMD_EXEC; c_address = 32'h0000_2008;
    w_en = 1'b1; w_index = 10'd2; w_data = 32'h3333_3333;
    tick(); w_en = 1'b0;
    check("coll early wait", 32'(c_response), 32'(R_WAIT));
    tick(); check("coll early resp", 32'(c_response), 32'(R_DONE));
    check("coll early data", c_load_data, 32'h3333_3333);
    c_cmd = CMD_NONE;
    last_data = 32'h3333_3333;
    tick();

    // Reset asserted during WAIT drops the access.
    c_cmd = CMD_EXEC; c_address = 32'h0000_2000;
    tick(); check("rst mid wait", 32'(c_response), 32'(R_WAIT));
    rst_n = 1'b0;
    tick();
    check("rst mid resp", 32'(c_response), 32'(R_IDLE));
    check("rst mid done", 32'(c_reset_done), 32'd0);
    check("rst mid data", c_load_data, 32'd0);
    rst_n = 1'b1;
    begin
      bit up = 1'b0;
      for (int c = 0; c < 20 && !up; c++) begin
        tick();
        check($sformatf("reinit no done c=%0d", c), 32'(c_response == R_DONE), 32'd0);
        if (c_reset_done) up = 1'b1;
      end
      c_cmd = CMD_NONE;
      if (!up) timeout_fail("reinit");
    end
    last_data = 32'd0;
    tick();
    run_access("ram retained", CMD_EXEC, 32'h0000_2000, R_DONE, 32'h0000_0013, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/corevx_imem_responder.md
Name: corevx_imem_responder

Overview:
- Responder end of the core's cache command interface: accepts c_cmd/c_address from the fetch stage and returns c_response, c_load_data and c_reset_done.
- Backed by a word-addressed on-chip instruction RAM with configurable access latency.
- Serves as the instruction-side memory for small configurations and for fetch-stage verification.
- Loaded through a simple write port driven by the bench or loader.

Parameters:
- BASE_ADDR, 32'h0000_2000, byte address of word 0.
- DEPTH_WORDS, 1024, RAM depth in 32-bit words; power of two, at least 2.
- LATENCY, 2, cycles from command accept to DONE; minimum 1.
- FLUSH_CYCLES, 4, cycles from FLUSH_ALL accept to DONE; minimum 1.
- RESET_CYCLES, 8, cycles after reset release before c_reset_done rises; minimum 1.
- PF_BASE, 32'h0000_3000, page-fault window base (used only with the optional feature).
- PF_SIZE, 32'h100, page-fault window size in bytes (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- c_cmd  in  4  command; uses `CACHE_CMD_*` encodings from corevx_cache.svh.
- c_address  in  32  byte address.
- c_response  out  4  response; uses `CACHE_RESPONSE_*` encodings.
- c_load_data  out  32  read data; valid only while c_response is DONE.
- c_reset_done  out  1  responder ready to accept commands.
- w_en  in  1  RAM backdoor write enable.
- w_index  in  log2(DEPTH_WORDS)  word index for the backdoor write.
- w_data  in  32  backdoor write data.

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk. While rst_n=0: state=INIT, counter=0, c_reset_done=0, c_response=IDLE, c_load_data=0. RAM contents are not reset and are retained.
- All outputs are registered.
- INIT: counter increments each cycle. After RESET_CYCLES cycles: c_reset_done=1, go to IDLE. Commands received during INIT are ignored.
- Command accept: a command is accepted in IDLE, or in any cycle where c_response is DONE or an error. This allows back-to-back accesses with no IDLE bubble.
- At accept, EXECUTE is checked in priority order; a failing check gives a 1-cycle error response in the next cycle, then IDLE:
  - c_address[1:0] != 0: MISSALIGNED.
  - PAGEFAULT window hit (optional feature only): PAGEFAULT.
  - c_address < BASE_ADDR or c_address >= BASE_ADDR + 4*DEPTH_WORDS: ACCESSFAULT. Compute in 33-bit to avoid wrap.
- Valid EXECUTE:
  - Latch word index = (c_address - BASE_ADDR) >> 2; go to BUSY.
  - c_response=WAIT for LATENCY-1 cycles, then DONE for exactly 1 cycle with c_load_data = RAM[index]. If LATENCY=1, DONE comes the next cycle.
- FLUSH_ALL: go to FLUSH. WAIT for FLUSH_CYCLES-1 cycles, then DONE for 1 cycle with c_load_data=0. No state is actually invalidated.
- NONE, or any other encoding, at an accept point: next c_response=IDLE.
- During WAIT: c_cmd and c_address are ignored; the requestor holds them. A latched access is never aborted except by reset.
- c_load_data: holds its last DONE value outside DONE; 0 after reset.
- Backdoor write: w_en writes RAM[w_index] at the clock edge.
  - If the write hits the word an in-flight access reads, the DONE data is the value present at the DONE-producing edge; the RAM read occurs on the final WAIT cycle, so new data is returned if the write landed at least 1 cycle earlier.
  - w_en is legal in every state, including INIT.
- Reset mid-operation: the access is dropped. The next cycle shows c_response=IDLE and c_reset_done=0, and the INIT sequence restarts.
- Response encoding invariant: exactly one response per accepted non-NONE command. DONE or error lasts exactly one cycle.

Optional Feature:
- Macro: COREVX_IMEM_PAGEFAULT_EN.
- Defined: an EXECUTE with an aligned address satisfying PF_BASE <= addr < PF_BASE+PF_SIZE returns PAGEFAULT for 1 cycle. This takes priority over ACCESSFAULT, so it also applies outside the RAM range.
- Not defined: the PF_* parameters are unused and PAGEFAULT is never produced.

Test Plan:
- Reset release, RESET_CYCLES=8 -> c_reset_done=0 for 8 cycles, then 1; c_response=IDLE throughout.
- Backdoor write RAM[0]=32'h0000_0013, RAM[1]=32'h00A0_0093; EXECUTE 0x2000 held, then EXECUTE 0x2004 issued in the DONE cycle, LATENCY=2 -> WAIT,DONE(0x00000013),WAIT,DONE(0x00A00093) with no IDLE gap.
- EXECUTE 0x2002 -> MISSALIGNED for 1 cycle, then IDLE. EXECUTE 0x1FFC and 0x3000 with DEPTH_WORDS=1024 -> ACCESSFAULT. EXECUTE 0xFFFF_FFFC -> ACCESSFAULT, with no wrap-around false hit.
- FLUSH_ALL with FLUSH_CYCLES=4 -> 3 cycles WAIT, then 1 cycle DONE with c_load_data=0, then IDLE given c_cmd=NONE.
- rst_n=0 asserted during WAIT of an EXECUTE -> next cycle IDLE with c_reset_done=0, no DONE emitted; after re-init, RAM[0] still reads 0x00000013.
- With COREVX_IMEM_PAGEFAULT_EN, EXECUTE 0x3000 -> PAGEFAULT; EXECUTE 0x3002 -> MISSALIGNED. Without the macro, EXECUTE 0x3000 -> ACCESSFAULT.
